// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use, branch-after-load,
// taken-branch flush and data-memory freeze, plus saturating stall/flush counters.
module hazard_control_unit #(
    parameter int NB_OPERAND = 5,
    parameter int NB_COUNTER = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_OPERAND-1:0] i_if_id_rs1,
    input  logic [NB_OPERAND-1:0] i_if_id_rs2,
    input  logic                  i_if_id_use_rs1,
    input  logic                  i_if_id_use_rs2,
    input  logic                  i_if_id_branch,
    input  logic                  i_branch_taken,
    input  logic [NB_OPERAND-1:0] i_id_ex_rd,
    input  logic                  i_id_ex_mem_read,
    input  logic [NB_OPERAND-1:0] i_ex_mem_rd,
    input  logic                  i_ex_mem_mem_read,
    input  logic                  i_dmem_req,
    input  logic                  i_dmem_ready,
    input  logic                  i_cnt_clear,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_bubble,
    output logic                  o_id_ex_write,
    output logic                  o_ex_mem_write,
    output logic                  o_mem_wb_write,
    output logic [NB_COUNTER-1:0] o_stall_cycles,
    output logic [NB_COUNTER-1:0] o_flush_count
);

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        BR_LOAD_WAIT = 2'd1,
        FREEZE       = 2'd2
    } state_t;

    localparam logic [NB_COUNTER-1:0] CNT_ONE = NB_COUNTER'(1);
    localparam logic [NB_COUNTER-1:0] CNT_MAX = '1;

    state_t state, next_state;
    state_t ret_state, next_ret_state;
    state_t eval_state;

    logic lu, brmem, busy;

    always_comb begin
        lu = i_id_ex_mem_read && (i_id_ex_rd != '0) &&
             ((i_if_id_use_rs1 && (i_if_id_rs1 == i_id_ex_rd)) ||
              (i_if_id_use_rs2 && (i_if_id_rs2 == i_id_ex_rd)));
        brmem = i_if_id_branch && i_ex_mem_mem_read && (i_ex_mem_rd != '0) &&
                ((i_if_id_use_rs1 && (i_if_id_rs1 == i_ex_mem_rd)) ||
                 (i_if_id_use_rs2 && (i_if_id_rs2 == i_ex_mem_rd)));
        busy = i_dmem_req && !i_dmem_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= RUN;
            ret_state <= RUN;
        end else begin
            state     <= next_state;
            ret_state <= next_ret_state;
        end
    end

    // Leaving FREEZE replays the saved state's decision in the same cycle.
    always_comb begin
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_id_ex_write  = 1'b1;
        o_ex_mem_write = 1'b1;
        o_mem_wb_write = 1'b1;
        next_state     = state;
        next_ret_state = ret_state;
        eval_state     = (state == FREEZE) ? ret_state : state;

        if (busy) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_write  = 1'b0;
            o_ex_mem_write = 1'b0;
            o_mem_wb_write = 1'b0;
            next_state     = FREEZE;
            if (state != FREEZE)
                next_ret_state = state;
        end else begin
            next_ret_state = RUN;
            case (eval_state)
                BR_LOAD_WAIT: begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                    next_state     = RUN;
                end
                default: begin
                    next_state = RUN;
                    if (lu || brmem) begin
                        o_pc_write     = 1'b0;
                        o_if_id_write  = 1'b0;
                        o_id_ex_bubble = 1'b1;
                        if (lu && i_if_id_branch)
                            next_state = BR_LOAD_WAIT;
                    end else if (i_if_id_branch && i_branch_taken) begin
                        o_if_id_flush = 1'b1;
                    end
                end
            endcase
        end

        if (i_rst) begin
            o_pc_write     = 1'b1;
            o_if_id_write  = 1'b1;
            o_if_id_flush  = 1'b0;
            o_id_ex_bubble = 1'b0;
            o_id_ex_write  = 1'b1;
            o_ex_mem_write = 1'b1;
            o_mem_wb_write = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clear) begin
            o_stall_cycles <= '0;
            o_flush_count  <= '0;
        end else begin
            if (!o_pc_write && (o_stall_cycles != CNT_MAX))
                o_stall_cycles <= o_stall_cycles + CNT_ONE;
            if (o_if_id_flush && (o_flush_count != CNT_MAX))
                o_flush_count <= o_flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; NB_COUNTER=4 so saturation is reachable.
module tb_hazard_control_unit;

    localparam int NBO = 5;
    localparam int NBC = 4;

    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write, ex_mem_write, mem_wb_write}
    localparam logic [6:0] C_RUN    = 7'b1100111;
    localparam logic [6:0] C_STALL  = 7'b0001111;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_FLUSH  = 7'b1110111;

    logic           clk = 1'b0;
    logic           rst;
    logic [NBO-1:0] rs1, rs2, id_ex_rd, ex_mem_rd;
    logic           use_rs1, use_rs2, branch, taken, id_ex_mr, ex_mem_mr;
    logic           dmem_req, dmem_ready, cnt_clear;
    logic           pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic           id_ex_write, ex_mem_write, mem_wb_write;
    logic [NBC-1:0] stall_cycles, flush_count;
    logic [6:0]     ctl;

    int checks = 0;
    int fails  = 0;

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                  id_ex_write, ex_mem_write, mem_wb_write};

    always #5 clk = ~clk;

    hazard_control_unit #(.NB_OPERAND(NBO), .NB_COUNTER(NBC)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_id_rs1(rs1), .i_if_id_rs2(rs2),
        .i_if_id_use_rs1(use_rs1), .i_if_id_use_rs2(use_rs2),
        .i_if_id_branch(branch), .i_branch_taken(taken),
        .i_id_ex_rd(id_ex_rd), .i_id_ex_mem_read(id_ex_mr),
        .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_mem_read(ex_mem_mr),
        .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
        .i_cnt_clear(cnt_clear),
        .o_pc_write(pc_write), .o_if_id_write(if_id_write),
        .o_if_id_flush(if_id_flush), .o_id_ex_bubble(id_ex_bubble),
        .o_id_ex_write(id_ex_write), .o_ex_mem_write(ex_mem_write),
        .o_mem_wb_write(mem_wb_write),
        .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
    );

    task automatic idle();
        rst = 0; rs1 = 0; rs2 = 0; id_ex_rd = 0; ex_mem_rd = 0;
        use_rs1 = 0; use_rs2 = 0; branch = 0; taken = 0; id_ex_mr = 0; ex_mem_mr = 0;
        dmem_req = 0; dmem_ready = 0; cnt_clear = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic clear_counters();
        idle(); cnt_clear = 1;
        next_cycle();
        cnt_clear = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        id_ex_mr = 1; id_ex_rd = 5; use_rs1 = 1; rs1 = 5; dmem_req = 1;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RUN); end
        next_cycle(); next_cycle();
        checks++; if (stall_cycles !== 4'd0) begin fails++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cycles); end
        checks++; if (flush_count !== 4'd0) begin fails++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_count); end
        idle();
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_counters();
        id_ex_mr = 1; id_ex_rd = 5; use_rs1 = 1; rs1 = 5;
        @(negedge clk);
        checks++; if (ctl !== C_STALL) begin fails++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_STALL); end
        next_cycle();
        id_ex_mr = 0; id_ex_rd = 0;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL lu_resume got=%b exp=%b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cycles); end
        next_cycle(); idle();
    endtask

    task automatic test_branch_after_load();
        clear_counters();
        id_ex_mr = 1; id_ex_rd = 5; use_rs2 = 1; rs2 = 5; branch = 1; taken = 1;
        @(negedge clk);
        checks++; if (ctl !== C_STALL) begin fails++; $display("FAIL brl_stall1 got=%b exp=%b", ctl, C_STALL); end
        next_cycle();
        id_ex_mr = 0; id_ex_rd = 0; ex_mem_mr = 1; ex_mem_rd = 5;
        @(negedge clk);
        checks++; if (ctl !== C_STALL) begin fails++; $display("FAIL brl_stall2 got=%b exp=%b", ctl, C_STALL); end
        next_cycle();
        ex_mem_mr = 0; ex_mem_rd = 0;
        @(negedge clk);
        checks++; if (ctl !== C_FLUSH) begin fails++; $display("FAIL brl_flush got=%b exp=%b", ctl, C_FLUSH); end
        next_cycle(); idle();
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL brl_run got=%b exp=%b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 4'd2) begin fails++; $display("FAIL brl_stall_cnt got=%0d exp=2", stall_cycles); end
        checks++; if (flush_count !== 4'd1) begin fails++; $display("FAIL brl_flush_cnt got=%0d exp=1", flush_count); end
        next_cycle();
    endtask

    task automatic test_no_hazard();
        idle(); id_ex_mr = 1; id_ex_rd = 0; use_rs1 = 1; rs1 = 0;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL x0_load got=%b exp=%b", ctl, C_RUN); end
        next_cycle();
        idle(); ex_mem_mr = 1; ex_mem_rd = 7; use_rs1 = 1; rs1 = 7;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL mem_load_nonbranch got=%b exp=%b", ctl, C_RUN); end
        next_cycle();
        branch = 1;
        @(negedge clk);
        checks++; if (ctl !== C_STALL) begin fails++; $display("FAIL mem_load_branch got=%b exp=%b", ctl, C_STALL); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL brmem_single got=%b exp=%b", ctl, C_RUN); end
        next_cycle();
    endtask

    task automatic test_freeze_in_blw();
        clear_counters();
        id_ex_mr = 1; id_ex_rd = 5; use_rs1 = 1; rs1 = 5; branch = 1;
        @(negedge clk);
        checks++; if (ctl !== C_STALL) begin fails++; $display("FAIL fz_enter_blw got=%b exp=%b", ctl, C_STALL); end
        next_cycle();
        id_ex_mr = 0; id_ex_rd = 0; ex_mem_mr = 1; ex_mem_rd = 5;
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL fz_freeze%0d got=%b exp=%b", i, ctl, C_FREEZE); end
            next_cycle();
        end
        dmem_ready = 1;
        @(negedge clk);
        checks++; if (ctl !== C_STALL) begin fails++; $display("FAIL fz_blw_resume got=%b exp=%b", ctl, C_STALL); end
        next_cycle();
        idle(); use_rs1 = 1; rs1 = 5; branch = 1;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL fz_back_run got=%b exp=%b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 4'd5) begin fails++; $display("FAIL fz_stall_cnt got=%0d exp=5", stall_cycles); end
        next_cycle(); idle();
    endtask

    task automatic test_taken_while_busy();
        clear_counters();
        branch = 1; taken = 1; dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL tb_freeze%0d got=%b exp=%b", i, ctl, C_FREEZE); end
            next_cycle();
        end
        dmem_ready = 1;
        @(negedge clk);
        checks++; if (ctl !== C_FLUSH) begin fails++; $display("FAIL tb_flush got=%b exp=%b", ctl, C_FLUSH); end
        next_cycle(); idle();
        @(negedge clk);
        checks++; if (flush_count !== 4'd1) begin fails++; $display("FAIL tb_flush_cnt got=%0d exp=1", flush_count); end
        checks++; if (stall_cycles !== 4'd2) begin fails++; $display("FAIL tb_stall_cnt got=%0d exp=2", stall_cycles); end
        next_cycle();
    endtask

    task automatic test_reset_in_blw();
        idle(); id_ex_mr = 1; id_ex_rd = 9; use_rs2 = 1; rs2 = 9; branch = 1;
        @(negedge clk);
        checks++; if (ctl !== C_STALL) begin fails++; $display("FAIL rb_enter got=%b exp=%b", ctl, C_STALL); end
        next_cycle();
        idle(); rst = 1;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL rb_during_rst got=%b exp=%b", ctl, C_RUN); end
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL rb_after_rst got=%b exp=%b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 4'd0) begin fails++; $display("FAIL rb_cnt got=%0d exp=0", stall_cycles); end
        next_cycle();
    endtask

    task automatic test_saturation();
        clear_counters();
        id_ex_mr = 1; id_ex_rd = 3; use_rs1 = 1; rs1 = 3;
        for (int i = 0; i < 20; i++) next_cycle();
        @(negedge clk);
        checks++; if (stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_hold got=%0d exp=15", stall_cycles); end
        cnt_clear = 1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (stall_cycles !== 4'd0) begin fails++; $display("FAIL sat_clear got=%0d exp=0", stall_cycles); end
        next_cycle();
    endtask

    initial begin
        idle(); rst = 1;
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_no_hazard();
        test_freeze_in_blw();
        test_taken_while_busy();
        test_reset_in_blw();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush controller for the 5-stage RV32I pipeline. It works alongside forwarding_unit and drives the pipeline-register and PC write enables.
- Handles the hazards that forwarding cannot cover:
  - load-use
  - branch-in-ID dependent on an in-flight load
  - taken-branch IF/ID flush
  - data-memory wait freeze
- Contains a small FSM for the two-cycle branch-after-load stall and a freeze return state.
- Contains saturating performance counters for stall cycles and flushes.

Parameters:
NB_OPERAND, 5, register index width
NB_COUNTER, 32, width of performance counters

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_if_id_rs1  in  NB_OPERAND  rs1 of instruction in ID
i_if_id_rs2  in  NB_OPERAND  rs2 of instruction in ID
i_if_id_use_rs1  in  1  ID instruction reads rs1
i_if_id_use_rs2  in  1  ID instruction reads rs2
i_if_id_branch  in  1  ID instruction is branch/JALR (resolved in ID)
i_branch_taken  in  1  ID branch resolved taken (valid when i_if_id_branch)
i_id_ex_rd  in  NB_OPERAND  rd of instruction in EX
i_id_ex_mem_read  in  1  EX instruction is a load
i_ex_mem_rd  in  NB_OPERAND  rd of instruction in MEM
i_ex_mem_mem_read  in  1  MEM instruction is a load
i_dmem_req  in  1  MEM stage has an active data access
i_dmem_ready  in  1  data memory completes access this cycle
i_cnt_clear  in  1  synchronous clear of counters
o_pc_write  out  1  PC update enable
o_if_id_write  out  1  IF/ID register enable
o_if_id_flush  out  1  replace IF/ID contents with NOP
o_id_ex_bubble  out  1  load NOP into ID/EX
o_id_ex_write  out  1  ID/EX register enable
o_ex_mem_write  out  1  EX/MEM register enable
o_mem_wb_write  out  1  MEM/WB register enable
o_stall_cycles  out  NB_COUNTER  cycles with o_pc_write=0
o_flush_count  out  NB_COUNTER  number of flushes issued

Behaviour:
- Single clock i_clk; reset i_rst synchronous, active-high.
- On reset:
  - state=RUN; ret_state=RUN; counters=0.
  - While i_rst=1, all *_write outputs are 1, and o_if_id_flush and o_id_ex_bubble are 0.
- Control outputs are combinational from the state and the current inputs, taking effect in the same cycle (zero latency).
- Hazard terms (rd==0 never hazards):
  - m1 = use_rs1 && rs1==rd; m2 = use_rs2 && rs2==rd.
  - lu = i_id_ex_mem_read && i_id_ex_rd!=0 && (m1||m2), evaluated against i_id_ex_rd.
  - brmem = i_if_id_branch && i_ex_mem_mem_read && i_ex_mem_rd!=0 && (m1||m2), evaluated against i_ex_mem_rd.
  - busy = i_dmem_req && !i_dmem_ready.
- STALL action: pc_write=0, if_id_write=0, id_ex_bubble=1; all other enables 1, flush 0.
- FREEZE action: all *_write=0, bubble=0, flush=0.
- States RUN, BR_LOAD_WAIT, FREEZE.
- Priority within RUN and BR_LOAD_WAIT: busy > hazard > flush.
- RUN:
  - busy: FREEZE action; ret_state=RUN; go to FREEZE.
  - else lu && i_if_id_branch: STALL; go to BR_LOAD_WAIT.
  - else lu || brmem: STALL; stay in RUN.
  - else i_if_id_branch && i_branch_taken: o_if_id_flush=1, all enables 1.
  - else: all enables 1.
- BR_LOAD_WAIT:
  - busy: FREEZE action; ret_state=BR_LOAD_WAIT; go to FREEZE.
  - else STALL unconditionally (no re-evaluation of rs matching); go to RUN.
- FREEZE:
  - busy: FREEZE action; stay in FREEZE.
  - else evaluate exactly as ret_state would this cycle, including its transition; ret_state cleared to RUN.
- Taken branch during a stall or freeze: no flush. The branch stays in ID and flushes on the first non-stalled cycle.
- Counters:
  - o_stall_cycles increments on each cycle with o_pc_write=0 and i_rst=0.
  - o_flush_count increments on each cycle with o_if_id_flush=1.
  - Both saturate at all-ones (no wrap).
  - i_cnt_clear zeros both and takes priority over increment.
- Reset mid-stall (incl. BR_LOAD_WAIT/FREEZE): next cycle state=RUN with no residual stall.

Test Plan:
- EX load rd=x5, ID add uses rs1=x5, no branch -> exactly 1 STALL cycle (pc_write=0, bubble=1), o_stall_cycles=1, state stays RUN.
- EX load rd=x5, ID beq uses rs2=x5 -> 2 consecutive STALL cycles (RUN->BR_LOAD_WAIT->RUN), then taken beq gives o_if_id_flush=1; counters stall=2, flush=1.
- EX load rd=x0, ID uses rs1=x0 -> no stall; MEM load rd=x7 with ID non-branch using x7 -> no stall.
- In BR_LOAD_WAIT, i_dmem_req=1 with i_dmem_ready=0 for 3 cycles -> all enables 0 for 3 cycles, then 1 STALL cycle, then RUN; stall count +4.
- Taken branch in ID while busy -> flush=0 during freeze, flush=1 on the first ready cycle; i_rst asserted in BR_LOAD_WAIT -> next cycle pc_write=1, state RUN.
- Preload o_stall_cycles to all-ones (force stalls, NB_COUNTER=4): a 20-cycle stall -> counter holds 15; i_cnt_clear together with a stall -> counter reads 0.
